// File: rtl/gshare_btb_predictor_pkg.sv
// Shared types for the gshare/BTB branch predictor: retire packet, BTB entry and
// branch-type encoding.
package gshare_btb_predictor_pkg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011
   } rv32i_opcode;

   typedef struct packed {
      rv32i_opcode opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
   } rv32i_inst_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
   } rv32i_data_t;

   typedef struct packed {
      logic        valid;
      rv32i_inst_t inst;
      rv32i_data_t data;
   } rv32i_packet_t;

   typedef enum logic [1:0] {
      BP_BR   = 2'd0,
      BP_JUMP = 2'd1,
      BP_CALL = 2'd2,
      BP_RET  = 2'd3
   } bp_type_t;

   // Tag holds pc[31:BTB_IDX+2] zero-extended, so one field width fits any BTB size.
   localparam int BTB_TAG_W = 30;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [31:0]          target;
      bp_type_t             btype;
   } btb_entry_t;

   function automatic logic is_link_reg(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

endpackage

// File: rtl/gshare_btb_predictor_bp_ras.sv
// Circular return-address stack: pop-then-push in one cycle, overwrites the oldest
// entry when full, ignores pops when empty.
module bp_ras #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [31:0]              push_addr_i,
   output logic [31:0]              top_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;
   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

   logic [31:0] mem_q [DEPTH];
   ptr_t        ptr_q, ptr_d, ptr_pop;
   cnt_t        count_q, count_d, count_pop;
   logic        do_pop;

   // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
   always_comb begin
      do_pop    = pop_i && (count_q != '0);
      ptr_pop   = do_pop ? ptr_q - ptr_t'(1) : ptr_q;
      count_pop = do_pop ? count_q - cnt_t'(1) : count_q;
      ptr_d     = push_i ? ptr_pop + ptr_t'(1) : ptr_pop;
      count_d   = (push_i && (count_pop != CNT_FULL)) ? count_pop + cnt_t'(1) : count_pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: the storage array has no reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[ptr_pop] <= push_addr_i;
   end

   assign top_o   = mem_q[ptr_q - ptr_t'(1)];
   assign count_o = count_q;

endmodule

// File: rtl/gshare_btb_predictor.sv
// IF-stage predictor: gshare PHT plus tagged, typed BTB, trained from WB through a
// one-cycle write stage. Define BP_RAS_EN to add a return-address stack for RET hits.
module gshare_btb_predictor
   import gshare_btb_predictor_pkg::*;
#(
   parameter int GHR_W     = 8,
   parameter int PHT_IDX   = 10,
   parameter int CTR_W     = 2,
   parameter int BTB_IDX   = 6,
   parameter int RAS_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_buffers,
   input  logic [31:0]   if_pc,
   output logic [31:0]   if_pred_pc,
   output logic          if_pred_taken,
   input  rv32i_packet_t wb_pkt
);
   localparam int PHT_N = 1 << PHT_IDX;
   localparam int BTB_N = 1 << BTB_IDX;
   typedef logic [PHT_IDX-1:0] pht_idx_t;
   typedef logic [BTB_IDX-1:0] btb_idx_t;
   typedef logic [CTR_W-1:0]   ctr_t;
   localparam ctr_t CTR_MAX     = '1;
   localparam ctr_t CTR_WEAK_NT = ctr_t'((1 << (CTR_W - 1)) - 1);

   generate
      if (GHR_W < 2 || GHR_W > PHT_IDX) begin : g_bad_ghr
         $error("GHR_W must lie in 2..PHT_IDX");
      end
      if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
         $error("RAS_DEPTH must be a power of two >= 2");
      end
   endgenerate

   function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
      return BTB_TAG_W'(pc >> (BTB_IDX + 2));
   endfunction

   ctr_t             pht_q [PHT_N];
   btb_entry_t       btb_q [BTB_N];
   logic [GHR_W-1:0] ghr_q, ghr_d;

   logic       pht_we_q, pht_we_d;
   pht_idx_t   pht_widx_q, pht_widx_d;
   ctr_t       pht_wdata_q, pht_wdata_d;
   logic       btb_we_q, btb_we_d;
   btb_idx_t   btb_widx_q, btb_widx_d;
   btb_entry_t btb_wdata_q, btb_wdata_d;

   logic     wb_is_br, wb_is_jal, wb_is_jalr, wb_upd, wb_taken, wb_call;
   bp_type_t wb_type;
   pht_idx_t wb_pidx;
   ctr_t     wb_ctr_cur;

   always_comb begin
      wb_is_br   = wb_pkt.inst.opcode == op_br;
      wb_is_jal  = wb_pkt.inst.opcode == op_jal;
      wb_is_jalr = wb_pkt.inst.opcode == op_jalr;
      wb_upd     = load_buffers && wb_pkt.valid && (wb_is_br || wb_is_jal || wb_is_jalr);
      wb_taken   = wb_pkt.data.next_pc != (wb_pkt.data.pc + 32'd4);
      wb_call    = (wb_is_jal || wb_is_jalr) && is_link_reg(wb_pkt.inst.rd);

      if (wb_is_br)
         wb_type = BP_BR;
      else if (wb_call)
         wb_type = BP_CALL;
      else if (wb_is_jalr && wb_pkt.inst.rd == 5'd0 && is_link_reg(wb_pkt.inst.rs1))
         wb_type = BP_RET;
      else
         wb_type = BP_JUMP;

      // Read-after-write on the same index in consecutive cycles must see the pending value.
      wb_pidx    = wb_pkt.data.pc[PHT_IDX+1:2] ^ pht_idx_t'(ghr_q);
      wb_ctr_cur = (pht_we_q && pht_widx_q == wb_pidx) ? pht_wdata_q : pht_q[wb_pidx];

      pht_we_d    = wb_upd && wb_is_br;
      pht_widx_d  = wb_pidx;
      if (wb_taken)
         pht_wdata_d = (wb_ctr_cur == CTR_MAX) ? wb_ctr_cur : wb_ctr_cur + ctr_t'(1);
      else
         pht_wdata_d = (wb_ctr_cur == '0) ? wb_ctr_cur : wb_ctr_cur - ctr_t'(1);

      btb_we_d    = wb_upd && wb_taken;
      btb_widx_d  = wb_pkt.data.pc[BTB_IDX+1:2];
      btb_wdata_d = '{valid: 1'b1, tag: tag_of(wb_pkt.data.pc),
                      target: wb_pkt.data.next_pc, btype: wb_type};

      ghr_d = (wb_upd && wb_is_br) ? {ghr_q[GHR_W-2:0], wb_taken} : ghr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q       <= '0;
         pht_we_q    <= 1'b0;
         pht_widx_q  <= '0;
         pht_wdata_q <= '0;
         btb_we_q    <= 1'b0;
         btb_widx_q  <= '0;
         btb_wdata_q <= '0;
         for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_WEAK_NT;
         for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         ghr_q       <= ghr_d;
         pht_we_q    <= pht_we_d;
         pht_widx_q  <= pht_widx_d;
         pht_wdata_q <= pht_wdata_d;
         btb_we_q    <= btb_we_d;
         btb_widx_q  <= btb_widx_d;
         btb_wdata_q <= btb_wdata_d;
         if (pht_we_q) pht_q[pht_widx_q] <= pht_wdata_q;
         if (btb_we_q) btb_q[btb_widx_q] <= btb_wdata_q;
      end
   end

   pht_idx_t    pred_pidx;
   btb_idx_t    pred_bidx;
   btb_entry_t  pred_entry;
   ctr_t        pred_ctr;
   logic        pred_hit, pred_redirect;
   logic [31:0] pred_target;

   assign pred_pidx  = if_pc[PHT_IDX+1:2] ^ pht_idx_t'(ghr_q);
   assign pred_bidx  = if_pc[BTB_IDX+1:2];
   assign pred_entry = btb_q[pred_bidx];
   assign pred_ctr   = pht_q[pred_pidx];
   assign pred_hit   = pred_entry.valid && (pred_entry.tag == tag_of(if_pc));
   assign pred_redirect = pred_hit && ((pred_entry.btype != BP_BR) || pred_ctr[CTR_W-1]);

`ifdef BP_RAS_EN
   logic [31:0]                  ras_top;
   logic [$clog2(RAS_DEPTH):0]   ras_count;
   logic                         ras_push, ras_pop;

   // A jalr with both link registers (rd != rs1) is a coroutine swap: pop, then push.
   assign ras_push = wb_upd && wb_call;
   assign ras_pop  = wb_upd && wb_is_jalr && is_link_reg(wb_pkt.inst.rs1) &&
                     ((wb_pkt.inst.rd == 5'd0) ||
                      (is_link_reg(wb_pkt.inst.rd) && wb_pkt.inst.rd != wb_pkt.inst.rs1));

   bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .push_addr_i (wb_pkt.data.pc + 32'd4),
      .top_o       (ras_top),
      .count_o     (ras_count)
   );

   assign pred_target = (pred_entry.btype == BP_RET && ras_count != '0) ? ras_top
                                                                        : pred_entry.target;
`else
   assign pred_target = pred_entry.target;
`endif

   assign if_pred_pc    = pred_redirect ? pred_target : if_pc + 32'd4;
   assign if_pred_taken = pred_redirect;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor: reset, PHT forwarding, BTB no-bypass,
// load_buffers gating, RAS (when BP_RAS_EN) and reset during a pending write.
module tb_gshare_btb_predictor;
   import gshare_btb_predictor_pkg::*;

   logic          clk;
   logic          rst;
   logic          load_buffers;
   logic [31:0]   if_pc;
   logic [31:0]   if_pred_pc;
   logic          if_pred_taken;
   rv32i_packet_t wb_pkt;

   int vectors;
   int miscompares;
   logic [31:0] exp_pc;
   logic        exp_tk;

   gshare_btb_predictor dut (
      .clk           (clk),
      .rst           (rst),
      .load_buffers  (load_buffers),
      .if_pc         (if_pc),
      .if_pred_pc    (if_pred_pc),
      .if_pred_taken (if_pred_taken),
      .wb_pkt        (wb_pkt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents one retiring instruction for exactly one clock.
   task automatic retire(input rv32i_opcode op, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                         input logic [31:0] a_pc, input logic [31:0] a_npc, input logic lb);
      @(negedge clk);
      wb_pkt = '{valid: 1'b1, inst: '{opcode: op, rd: a_rd, rs1: a_rs1},
                 data: '{pc: a_pc, next_pc: a_npc}};
      load_buffers = lb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wb_pkt.valid = 1'b0;
         load_buffers = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      if_pc = 32'h100; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h104}) begin
         miscompares++;
         $display("FAIL reset_during: got tk=%0b pc=%h want tk=0 pc=00000104", if_pred_taken, if_pred_pc);
      end
      @(negedge clk);
      rst = 1'b0;
      if_pc = 32'h100; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h104}) begin
         miscompares++;
         $display("FAIL reset_after: got tk=%0b pc=%h want tk=0 pc=00000104", if_pred_taken, if_pred_pc);
      end
      if_pc = 32'hFFFF_FFFC; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL pc_wrap: got tk=%0b pc=%h want tk=0 pc=00000000", if_pred_taken, if_pred_pc);
      end
   endtask

   task automatic test_pht_forward;
      // Eight taken branches at 0x20C drive GHR to 0xFF, which taken branches then hold.
      for (int i = 0; i < 8; i++) retire(op_br, 5'd0, 5'd0, 32'h20C, 32'h240, 1'b1);
      for (int i = 0; i < 3; i++) retire(op_br, 5'd0, 5'd0, 32'h200, 32'h180, 1'b1);
      idle(2);
      if_pc = 32'h200; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h180}) begin
         miscompares++;
         $display("FAIL pht_taken: got tk=%0b pc=%h want tk=1 pc=00000180", if_pred_taken, if_pred_pc);
      end
      if_pc = 32'h20C; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h210}) begin
         miscompares++;
         $display("FAIL pht_weak_nt: got tk=%0b pc=%h want tk=0 pc=00000210", if_pred_taken, if_pred_pc);
      end
      // Two not-taken retires hitting index 0x7F back-to-back: 11 -> 10 -> 01 via forwarding.
      retire(op_br, 5'd0, 5'd0, 32'h200, 32'h204, 1'b1);
      retire(op_br, 5'd0, 5'd0, 32'h204, 32'h208, 1'b1);
      idle(2);
      if_pc = 32'h20C; #1;
      exp_pc = 32'h210; exp_tk = 1'b0;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {exp_tk, exp_pc}) begin
         miscompares++;
         $display("FAIL pht_fwd_nt: got tk=%0b pc=%h want tk=%0b pc=%h", if_pred_taken, if_pred_pc, exp_tk, exp_pc);
      end
      if_pc = 32'h200; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h204}) begin
         miscompares++;
         $display("FAIL ghr_shift0: got tk=%0b pc=%h want tk=0 pc=00000204", if_pred_taken, if_pred_pc);
      end
   endtask

   task automatic test_no_bypass;
      retire(op_jal, 5'd0, 5'd0, 32'h300, 32'h400, 1'b1);
      idle(1);
      if_pc = 32'h300; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h304}) begin
         miscompares++;
         $display("FAIL no_bypass: got tk=%0b pc=%h want tk=0 pc=00000304", if_pred_taken, if_pred_pc);
      end
      idle(1);
      if_pc = 32'h300; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h400}) begin
         miscompares++;
         $display("FAIL jal_hit: got tk=%0b pc=%h want tk=1 pc=00000400", if_pred_taken, if_pred_pc);
      end
      if_pc = 32'h400; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h404}) begin
         miscompares++;
         $display("FAIL tag_miss: got tk=%0b pc=%h want tk=0 pc=00000404", if_pred_taken, if_pred_pc);
      end
   endtask

   task automatic test_load_buffers;
      retire(op_br, 5'd0, 5'd0, 32'h20C, 32'h210, 1'b1);   // GHR FC -> F8
      retire(op_br, 5'd0, 5'd0, 32'h20C, 32'h210, 1'b0);   // ignored
      retire(op_br, 5'd0, 5'd0, 32'h230, 32'h280, 1'b0);   // ignored
      retire(op_br, 5'd0, 5'd0, 32'h228, 32'h260, 1'b1);   // idx 0x72 -> 10, GHR F1
      retire(op_br, 5'd0, 5'd0, 32'h230, 32'h280, 1'b0);   // pending write must still land
      idle(2);
      if_pc = 32'h230; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h234}) begin
         miscompares++;
         $display("FAIL lb_gate_btb: got tk=%0b pc=%h want tk=0 pc=00000234", if_pred_taken, if_pred_pc);
      end
      if_pc = 32'h20C; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h240}) begin
         miscompares++;
         $display("FAIL lb_gate_ghr: got tk=%0b pc=%h want tk=1 pc=00000240", if_pred_taken, if_pred_pc);
      end
      if_pc = 32'h228; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h22C}) begin
         miscompares++;
         $display("FAIL lb_new_br: got tk=%0b pc=%h want tk=0 pc=0000022c", if_pred_taken, if_pred_pc);
      end
   endtask

   task automatic test_ras;
`ifdef BP_RAS_EN
      retire(op_jal,  5'd1, 5'd0, 32'h500, 32'h800, 1'b1);
      retire(op_jalr, 5'd0, 5'd1, 32'h600, 32'h504, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h504}) begin
         miscompares++;
         $display("FAIL ras_ret_btb: got tk=%0b pc=%h want tk=1 pc=00000504", if_pred_taken, if_pred_pc);
      end
      retire(op_jal, 5'd1, 5'd0, 32'h510, 32'h900, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h514}) begin
         miscompares++;
         $display("FAIL ras_top: got tk=%0b pc=%h want tk=1 pc=00000514", if_pred_taken, if_pred_pc);
      end
      for (int i = 0; i < 8; i++) retire(op_jal, 5'd5, 5'd0, 32'h2004 + 32'(8 * i), 32'h3000, 1'b1);
      for (int i = 0; i < 7; i++) retire(op_jalr, 5'd0, 5'd1, 32'h600, 32'h7000, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h2008}) begin
         miscompares++;
         $display("FAIL ras_oldest: got tk=%0b pc=%h want tk=1 pc=00002008", if_pred_taken, if_pred_pc);
      end
      retire(op_jalr, 5'd0, 5'd1, 32'h600, 32'h7000, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h7000}) begin
         miscompares++;
         $display("FAIL ras_full_cnt: got tk=%0b pc=%h want tk=1 pc=00007000", if_pred_taken, if_pred_pc);
      end
      retire(op_jal,  5'd1, 5'd0, 32'h510, 32'h900, 1'b1);
      retire(op_jalr, 5'd1, 5'd5, 32'h640, 32'h8000, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h644}) begin
         miscompares++;
         $display("FAIL ras_swap_push: got tk=%0b pc=%h want tk=1 pc=00000644", if_pred_taken, if_pred_pc);
      end
      retire(op_jalr, 5'd0, 5'd1, 32'h600, 32'h7000, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h7000}) begin
         miscompares++;
         $display("FAIL ras_swap_pop: got tk=%0b pc=%h want tk=1 pc=00007000", if_pred_taken, if_pred_pc);
      end
`else
      retire(op_jal,  5'd1, 5'd0, 32'h500, 32'h800, 1'b1);
      retire(op_jalr, 5'd0, 5'd1, 32'h600, 32'h504, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h504}) begin
         miscompares++;
         $display("FAIL ret_btb: got tk=%0b pc=%h want tk=1 pc=00000504", if_pred_taken, if_pred_pc);
      end
      retire(op_jal, 5'd1, 5'd0, 32'h510, 32'h900, 1'b1);
      idle(2);
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b1, 32'h504}) begin
         miscompares++;
         $display("FAIL ret_no_ras: got tk=%0b pc=%h want tk=1 pc=00000504", if_pred_taken, if_pred_pc);
      end
`endif
   endtask

   task automatic test_reset_drop;
      retire(op_jal, 5'd0, 5'd0, 32'h700, 32'h900, 1'b1);
      @(negedge clk);
      wb_pkt.valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if_pc = 32'h700; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h704}) begin
         miscompares++;
         $display("FAIL rst_drop: got tk=%0b pc=%h want tk=0 pc=00000704", if_pred_taken, if_pred_pc);
      end
      if_pc = 32'h600; #1;
      vectors++;
      if ({if_pred_taken, if_pred_pc} !== {1'b0, 32'h604}) begin
         miscompares++;
         $display("FAIL rst_btb_clr: got tk=%0b pc=%h want tk=0 pc=00000604", if_pred_taken, if_pred_pc);
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b1;
      load_buffers = 1'b0;
      if_pc        = 32'h0;
      wb_pkt       = '0;
      test_reset();
      test_pht_forward();
      test_no_bypass();
      test_load_buffers();
      test_ras();
      test_reset_drop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
